alu_seq: RTL

Clocked, parametrised successor to the team's 8-bit operation mux. A WIDTH-bit accumulator ALU with internal A/B registers, a valid/ready command handshake, status flags, and a multi-cycle barrel-free shifter that shifts by a variable amount, one bit per cycle. It sits between the front-panel/command source (switches, sequencer) and the LED/result display, replacing the level-triggered mux with a fully synchronous block.

---
 rtl/alu_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`timescale 1ns / 1ps
// alu_seq: WIDTH-bit accumulator ALU with internal A/B registers, a valid/ready
// command handshake, registered status flags and a serial (one bit per cycle)
// variable-distance shifter.
//
// Ports:
//   clk                   system clock, rising edge
//   reset_n               asynchronous active-low reset
//   op_valid / op_ready   command handshake (accept = both high at a clk edge)
//   opcode[3:0]           operation select
//   data_in[WIDTH-1:0]    load value for LOAD
//   y[WIDTH-1:0]          result register
//   done                  one-cycle pulse after a command completes
//   flag_z/n/c/v          zero, negative, carry/borrow/shift-out, signed overflow
//   a_led / b_led         continuous copies of the A / B registers
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] a_led,
  output logic [WIDTH-1:0] b_led
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpShl  = 4'h2;
  localparam logic [3:0] OpSar  = 4'h3;
  localparam logic [3:0] OpCmp  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;
  localparam logic [3:0] OpNand = 4'h8;
  localparam logic [3:0] OpNor  = 4'h9;
  localparam logic [3:0] OpXnor = 4'hA;
  localparam logic [3:0] OpNot  = 4'hB;
  localparam logic [3:0] OpNeg  = 4'hC;
  localparam logic [3:0] OpMovy = 4'hD;
  localparam logic [3:0] OpSwap = 4'hE;
  localparam logic [3:0] OpLoad = 4'hF;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ValOne = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CntOne = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_shl;
  logic             r_done;
  logic             r_z;
  logic             r_n;
  logic             r_c;
  logic             r_v;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [CW-1:0]    w_cnt;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_work_nx;
  logic             w_out_nx;

  // Extra top bit of the unsigned sum/difference is the carry / borrow.
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = {1'b0, r_a} - {1'b0, r_b};
  assign w_cnt      = r_b[CW-1:0];
  assign w_is_shift = (opcode == OpShl) || (opcode == OpSar);

  // Single-cycle result. Shift opcodes only land here with a zero count, which
  // passes A through with no shifted-out bit.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (opcode)
      OpAdd: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpSub: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
      end
      OpShl, OpSar: w_res = r_a;
      OpCmp: begin
        if (r_a == r_b) begin
          w_res = '0;
        end else if ($signed(r_a) > $signed(r_b)) begin
          w_res = ValOne;
        end else begin
          w_res = '1;
        end
      end
      OpAnd:  w_res = r_a & r_b;
      OpOr:   w_res = r_a | r_b;
      OpXor:  w_res = r_a ^ r_b;
      OpNand: w_res = ~(r_a & r_b);
      OpNor:  w_res = ~(r_a | r_b);
      OpXnor: w_res = ~(r_a ^ r_b);
      OpNot:  w_res = ~r_a;
      OpNeg: begin
        w_res = '0 - r_a;
        w_v   = (r_a == MinNeg);
      end
      default: w_res = '0;
    endcase
  end

  // One step of the serial shifter; w_out_nx is the bit leaving the word.
  always_comb begin
    if (r_shl) begin
      w_work_nx = {r_work[WIDTH-2:0], 1'b0};
      w_out_nx  = r_work[WIDTH-1];
    end else begin
      w_work_nx = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      w_out_nx  = r_work[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_shl   <= 1'b0;
      r_done  <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (op_valid) begin
            if (w_is_shift && (w_cnt != '0)) begin
              r_work  <= r_a;
              r_cnt   <= w_cnt;
              r_shl   <= (opcode == OpShl);
              r_state <= StShift;
            end else begin
              r_done <= 1'b1;
              case (opcode)
                OpMovy: r_a <= r_y;
                OpSwap: begin
                  r_a <= r_b;
                  r_b <= r_a;
                end
                OpLoad: r_a <= data_in;
                default: begin
                  r_y <= w_res;
                  r_z <= (w_res == '0);
                  r_n <= w_res[WIDTH-1];
                  r_c <= w_c;
                  r_v <= w_v;
                end
              endcase
            end
          end
        end
        StShift: begin
          r_work <= w_work_nx;
          r_cnt  <= r_cnt - CntOne;
          if (r_cnt == CntOne) begin
            r_y     <= w_work_nx;
            r_z     <= (w_work_nx == '0);
            r_n     <= w_work_nx[WIDTH-1];
            r_c     <= w_out_nx;
            r_v     <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign op_ready = (r_state == StIdle);
  assign y        = r_y;
  assign done     = r_done;
  assign flag_z   = r_z;
  assign flag_n   = r_n;
  assign flag_c   = r_c;
  assign flag_v   = r_v;
  assign a_led    = r_a;
  assign b_led    = r_b;

endmodule
